// File: rtl/wordle_pkg.sv
// wordle_pkg: shared widths, result codes, FSM encoding and a code-count helper for the guess scorer.
package wordle_pkg;
  localparam int WORD_LEN = 5;
  localparam int CHAR_W = 8;
  localparam int WORD_W = WORD_LEN * CHAR_W;
  typedef enum logic [1:0] {GRAY = 2'b00, YELLOW = 2'b01, GREEN = 2'b10} code_t;
  typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_DONE} state_t;
  function automatic logic [2:0] count_code(input logic [2*WORD_LEN-1:0] res, input code_t c);
    count_code = '0;
    for (int i = 0; i < WORD_LEN; i++) count_code += 3'(res[2*i +: 2] == c);
  endfunction
endpackage

// File: rtl/byte_sel.sv
// byte_sel: picks character i_idx of a packed word, character 0 being the most significant byte.
module byte_sel import wordle_pkg::*; (
  input  logic [WORD_W-1:0] i_word,
  input  logic [2:0]        i_idx,
  output logic [CHAR_W-1:0] o_byte
);
  logic [WORD_W-1:0] w_sh;
  assign w_sh = i_word << (6'(i_idx) * 6'(CHAR_W));
  assign o_byte = w_sh[WORD_W-1 -: CHAR_W];
endmodule

// File: rtl/guess_scorer.sv
// guess_scorer: sequential Wordle scorer, green pass then yellow pass one comparison per cycle.
// Define SCORE_STATS_EN to add green_cnt/yellow_cnt outputs.
module guess_scorer import wordle_pkg::*; (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_W-1:0]     guess,
  input  logic [WORD_W-1:0]     answer,
  output logic                  busy,
  output logic                  done,
  output logic [2*WORD_LEN-1:0] result,
  output logic                  win
`ifdef SCORE_STATS_EN
  ,
  output logic [2:0]            green_cnt,
  output logic [2:0]            yellow_cnt
`endif
);
  state_t r_state, w_next;
  logic [WORD_W-1:0] r_guess, r_answer;
  code_t r_res [WORD_LEN];
  logic [WORD_LEN-1:0] r_used;
  logic [2:0] r_g, r_a, w_aidx;
  logic r_done, r_win;
  logic [CHAR_W-1:0] w_gb, w_ab;
  logic w_match, w_last, w_skip, w_yhit, w_adv;
  // The green pass compares aligned positions, so the answer selector follows g there.
  assign w_aidx = (r_state == S_GREEN) ? r_g : r_a;
  byte_sel u_gsel (.i_word(r_guess), .i_idx(r_g), .o_byte(w_gb));
  byte_sel u_asel (.i_word(r_answer), .i_idx(w_aidx), .o_byte(w_ab));
  assign w_match = w_gb == w_ab;
  assign w_last = r_g == 3'(WORD_LEN - 1);
  assign w_skip = r_res[r_g] == GREEN;
  assign w_yhit = w_match && !r_used[r_a];
  assign w_adv = w_skip || w_yhit || r_a == 3'(WORD_LEN - 1);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = start ? S_GREEN : S_IDLE;
      S_GREEN:  w_next = w_last ? S_YELLOW : S_GREEN;
      S_YELLOW: w_next = (w_adv && w_last) ? S_DONE : S_YELLOW;
      S_DONE:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_guess <= '0;
      r_answer <= '0;
      r_res <= '{default: GRAY};
      r_used <= '0;
      r_g <= '0;
      r_a <= '0;
      r_done <= 1'b0;
      r_win <= 1'b0;
    end else begin
      r_done <= r_state == S_DONE;
      if (r_state == S_IDLE && start) begin
        r_guess <= guess;
        r_answer <= answer;
        r_res <= '{default: GRAY};
        r_used <= '0;
        r_g <= '0;
        r_a <= '0;
      end else if (r_state == S_GREEN) begin
        if (w_match) begin
          r_res[r_g] <= GREEN;
          r_used[r_g] <= 1'b1;
        end
        r_g <= w_last ? 3'd0 : r_g + 3'd1;
        r_a <= '0;
      end else if (r_state == S_YELLOW) begin
        if (!w_skip && w_yhit) begin
          r_res[r_g] <= YELLOW;
          r_used[r_a] <= 1'b1;
        end
        r_g <= !w_adv ? r_g : w_last ? 3'd0 : r_g + 3'd1;
        r_a <= w_adv ? 3'd0 : r_a + 3'd1;
      end else if (r_state == S_DONE) begin
        r_win <= count_code(result, GREEN) == 3'(WORD_LEN);
      end
    end
  end
  always_comb begin
    result = '0;
    for (int i = 0; i < WORD_LEN; i++) result[2*(WORD_LEN-1-i) +: 2] = r_res[i];
  end
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign win = r_win;
`ifdef SCORE_STATS_EN
  logic [2:0] r_gcnt, r_ycnt;
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_gcnt <= '0;
      r_ycnt <= '0;
    end else if (r_state == S_DONE) begin
      r_gcnt <= count_code(result, GREEN);
      r_ycnt <= count_code(result, YELLOW);
    end
  end
  assign green_cnt = r_gcnt;
  assign yellow_cnt = r_ycnt;
`endif
endmodule

// File: doc/guess_scorer.md
GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 SHALL have port: Clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request to score; sampled only in IDLE.
REQ-004 SHALL have port: guess  input  40  five ASCII letters; position 0 is bits [39:32].
REQ-005 SHALL have port: answer  input  40  word of the day, same packing as guess.
REQ-006 SHALL have port: busy  output  1  high in GREEN, YELLOW and DONE.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when result is valid.
REQ-008 SHALL have port: result  output  10  two bits per position; position 0 is bits [9:8]; 00 gray, 01 yellow, 10 green, 11 never driven.
REQ-009 SHALL have port: win  output  1  high when all five positions are green.

Function
REQ-010 SHALL implement states IDLE, GREEN, YELLOW and DONE.
REQ-011 SHALL, in IDLE with start=1, capture guess and answer, clear result and the used[4:0] mask, set index g=0, and enter GREEN.
REQ-012 SHALL, in GREEN, check one position per cycle for g=0..4: if guess[g]==answer[g], set result[g]=green and used[g]=1; after g=4, set g=0 and a=0 and enter YELLOW.
REQ-013 SHALL, in YELLOW, skip any g already green in one cycle: g++ and a=0.
REQ-014 SHALL, in YELLOW for a non-green g, test one answer position a per cycle, with priority: guess[g]==answer[a] and used[a]=0 gives yellow, sets used[a], then g++ and a=0; else a==4 leaves g gray, then g++ and a=0; else a++.
REQ-015 SHALL enter DONE when g=4 advances in YELLOW.
REQ-016 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-017 SHALL update win in the DONE cycle and hold result and win until the next accepted start.
REQ-018 SHALL take 5 GREEN cycles and 5 to 25 YELLOW cycles, so done comes 11 to 31 cycles after the start-sampling edge.
REQ-019 SHALL ignore start while busy; captured operands are unaffected by input changes after capture.
REQ-020 SHALL compare raw bytes, with no case folding or range check.

Reset
REQ-021 SHALL, on reset, go to IDLE immediately, including mid-operation.
REQ-022 SHALL reset result=0, win=0, done=0, busy=0, used=0, g=0 and a=0.
REQ-023 SHALL reset captured operands to 0.

Configuration
REQ-024 SHALL, with SCORE_STATS_EN defined, add outputs green_cnt[2:0] and yellow_cnt[2:0]: loaded in the DONE cycle, held like result, reset to 0.
REQ-025 SHALL, without SCORE_STATS_EN, not have these ports or counters; all other behaviour is identical.

Structure
REQ-026 SHALL take WORD_LEN=5, CHAR_W=8, the result codes GRAY/YELLOW/GREEN and the state encoding from shared package wordle_pkg.
REQ-027 SHALL use one sub-module, byte_sel, a 40-bit to 8-bit selector by 3-bit index, instanced for guess[g] and answer[a].

Verification
REQ-028 SHALL cover: guess "ROBOT", answer "ROBOT" -> result 10'h2AA, win=1, done 11 cycles after start.
REQ-029 SHALL cover: guess "ABBOT", answer "ROBOT" -> result 10'h02A, win=0, done at cycle 19.
REQ-030 SHALL cover: guess "ONION", answer "ROBIN" -> result 10'h112, duplicate O scored yellow once; with SCORE_STATS_EN, green_cnt=1 and yellow_cnt=2.
REQ-031 SHALL cover: start pulsed again and operands changed during scoring of "ABBOT"/"ROBOT" -> ignored, result still 10'h02A, single done.
REQ-032 SHALL cover: reset asserted in YELLOW -> next cycle busy=0, result=0, win=0, no done; a new start then scores normally.
